dmem_arbiter: RTL and testbench

Two-requester arbiter sharing the single-port synchronous data memory between the CPU core and an auxiliary master (program loader / debug port). The CPU phase sequencer requests memory during its fetch and rdmem phases and holds its phase while waiting for `cpu_ack`. The aux master uses the same request/ack protocol. The block owns the memory command port, chooses one requester per access and returns read data with an aligned acknowledge.

---
 rtl/dmem_arb_pkg.sv | 53 +++++
 rtl/dmem_arbiter_starve_cnt.sv | 34 +++
 rtl/dmem_arbiter.sv | 139 +++++++++++++
 tb/tb_dmem_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types, default widths and the idle-cycle priority rule for the
// data-memory arbiter.
package dmem_arb_pkg;

  localparam int DMEM_ADDR_W = 16;
  localparam int DMEM_DATA_W = 16;

  localparam logic [3:0] WAIT_CNT_MAX = 4'd15;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CPU  = 2'd1,
    ARB_AUX  = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_CPU  = 2'd1,
    SEL_AUX  = 2'd2
  } arb_sel_t;

  // Lock is absolute; otherwise CPU wins a conflict unless aux is overdue.
  function automatic arb_sel_t arb_pick(
    input logic cpu_req,
    input logic aux_req,
    input logic aux_lock,
    input logic aux_due
  );
    arb_sel_t sel;
    sel = SEL_NONE;
    if (aux_lock) begin
      if (aux_req) begin
        sel = SEL_AUX;
      end else begin
        sel = SEL_NONE;
      end
    end else if (cpu_req && aux_req) begin
      if (aux_due) begin
        sel = SEL_AUX;
      end else begin
        sel = SEL_CPU;
      end
    end else if (cpu_req) begin
      sel = SEL_CPU;
    end else if (aux_req) begin
      sel = SEL_AUX;
    end else begin
      sel = SEL_NONE;
    end
    return sel;
  endfunction

endpackage

// File: rtl/dmem_arbiter_starve_cnt.sv
// Saturating 4-bit count of arbitrations lost by aux, compared against a
// fixed limit so the arbiter's priority decision stays purely combinational.
module arb_starve_cnt
  import dmem_arb_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic ge_limit
);

  localparam logic [3:0] LIMIT_C = 4'(LIMIT);

  logic [3:0] cnt_r;

  // Lost-arbitration counter; clear has priority over increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= 4'd0;
    end else if (clr) begin
      cnt_r <= 4'd0;
    end else if (inc && (cnt_r != WAIT_CNT_MAX)) begin
      cnt_r <= cnt_r + 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign ge_limit = (cnt_r >= LIMIT_C);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port synchronous data memory between the CPU and an
// auxiliary master: grant in an idle cycle, ack plus read data one cycle later.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = DMEM_ADDR_W,
  parameter int DATA_W       = DMEM_DATA_W,
  parameter int AUX_MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic              aux_ack,
  output logic [DATA_W-1:0] aux_rdata,
  input  logic              aux_lock,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t state_r;
  arb_state_t state_next_s;
  arb_sel_t   sel_s;
  logic       aux_due_s;
  logic       wait_inc_s;
  logic       wait_clr_s;

  arb_starve_cnt #(
    .LIMIT (AUX_MAX_WAIT)
  ) u_starve_cnt (
    .clk      (clk),
    .rst      (rst),
    .inc      (wait_inc_s),
    .clr      (wait_clr_s),
    .ge_limit (aux_due_s)
  );

  // Grant selection: only an idle cycle outside reset may issue a grant.
  always_comb begin
    sel_s = SEL_NONE;
    if (rst) begin
      sel_s = SEL_NONE;
    end else if (state_r == ARB_IDLE) begin
      sel_s = arb_pick(cpu_req, aux_req, aux_lock, aux_due_s);
    end else begin
      sel_s = SEL_NONE;
    end
  end

  // A CPU grant implies no lock, so a present aux request has just lost.
  assign wait_inc_s = (sel_s == SEL_CPU) && aux_req;
  assign wait_clr_s = (sel_s == SEL_AUX);

  // Next state follows the grant; ack cycles always fall back to idle.
  always_comb begin
    state_next_s = ARB_IDLE;
    case (sel_s)
      SEL_CPU: state_next_s = ARB_CPU;
      SEL_AUX: state_next_s = ARB_AUX;
      default: state_next_s = ARB_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ARB_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Memory command mux; everything is zero when nothing is granted.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    case (sel_s)
      SEL_CPU: begin
        mem_en    = 1'b1;
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      SEL_AUX: begin
        mem_en    = 1'b1;
        mem_we    = aux_we;
        mem_addr  = aux_addr;
        mem_wdata = aux_wdata;
      end
      default: begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
      end
    endcase
  end

  // Ack/rdata fan-out; reset in an ack cycle drops the pending ack.
  always_comb begin
    cpu_ack   = 1'b0;
    aux_ack   = 1'b0;
    cpu_rdata = {DATA_W{1'b0}};
    aux_rdata = {DATA_W{1'b0}};
    if (rst) begin
      cpu_ack = 1'b0;
      aux_ack = 1'b0;
    end else begin
      case (state_r)
        ARB_CPU: begin
          cpu_ack   = 1'b1;
          cpu_rdata = mem_rdata;
        end
        ARB_AUX: begin
          aux_ack   = 1'b1;
          aux_rdata = mem_rdata;
        end
        default: begin
          cpu_ack = 1'b0;
          aux_ack = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a spec-level model checked every cycle,
// plus literal expectations pinned to specific cycles.
module tb_dmem_arbiter;

  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int MAXW = 4;

  localparam int S_MEM_EN    = 0;
  localparam int S_MEM_ADDR  = 1;
  localparam int S_CPU_ACK   = 2;
  localparam int S_CPU_RDATA = 3;
  localparam int S_AUX_ACK   = 4;
  localparam int S_MEM_WE    = 5;
  localparam int S_MEM_WDATA = 6;
  localparam int S_AUX_RDATA = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, aux_req, aux_we, aux_lock;
  logic [AW-1:0] cpu_addr, aux_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, aux_wdata, mem_wdata, mem_rdata;
  logic [DW-1:0] cpu_rdata, aux_rdata;
  logic          cpu_ack, aux_ack, mem_en, mem_we;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .AUX_MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_ack(aux_ack), .aux_rdata(aux_rdata), .aux_lock(aux_lock),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_cnt = 0;

  typedef struct {
    int          when;
    int          sig;
    logic [15:0] val;
  } lit_t;
  lit_t lq[$];

  logic [DW-1:0] mem_arr [0:4095];
  logic [DW-1:0] ref_mem [0:4095];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc_cnt);
    end
  endtask

  task automatic chk_lit(input int sig, input logic [15:0] val);
    case (sig)
      S_MEM_EN:    chk("lit_mem_en",    32'(mem_en),    32'(val));
      S_MEM_ADDR:  chk("lit_mem_addr",  32'(mem_addr),  32'(val));
      S_CPU_ACK:   chk("lit_cpu_ack",   32'(cpu_ack),   32'(val));
      S_CPU_RDATA: chk("lit_cpu_rdata", 32'(cpu_rdata), 32'(val));
      S_AUX_ACK:   chk("lit_aux_ack",   32'(aux_ack),   32'(val));
      S_MEM_WE:    chk("lit_mem_we",    32'(mem_we),    32'(val));
      S_MEM_WDATA: chk("lit_mem_wdata", 32'(mem_wdata), 32'(val));
      default:     chk("lit_aux_rdata", 32'(aux_rdata), 32'(val));
    endcase
  endtask

  task automatic pin(input int off, input int sig, input logic [15:0] val);
    lit_t e;
    e.when = cyc_cnt + off;
    e.sig  = sig;
    e.val  = val;
    lq.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Synchronous memory: write commits at the grant edge, read data next cycle.
  initial begin
    for (int i = 0; i < 4096; i++) mem_arr[i] = 16'h0000;
    mem_arr[12'h010] = 16'h1234;
    mem_arr[12'h020] = 16'h5555;
    mem_arr[12'h030] = 16'h6666;
    mem_rdata = 16'h0000;
    forever begin
      @(posedge clk);
      if (mem_en === 1'b1) begin
        if (mem_we === 1'b1) mem_arr[mem_addr[11:0]] <= mem_wdata;
        else mem_rdata <= mem_arr[mem_addr[11:0]];
      end
    end
  end

  // Behavioural model and the single compare process.
  initial begin
    int          pend;
    logic        pend_we;
    logic [15:0] pend_addr;
    int          wcnt;
    int          g;
    pend = 0; pend_we = 1'b0; pend_addr = 16'h0000; wcnt = 0; g = 0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 16'h0000;
    ref_mem[12'h010] = 16'h1234;
    ref_mem[12'h020] = 16'h5555;
    ref_mem[12'h030] = 16'h6666;
    forever begin
      @(negedge clk);
      foreach (lq[i]) if (lq[i].when == cyc_cnt) chk_lit(lq[i].sig, lq[i].val);
      if (rst === 1'b1) begin
        chk("rst_mem_en",    32'(mem_en),    32'd0);
        chk("rst_mem_we",    32'(mem_we),    32'd0);
        chk("rst_mem_addr",  32'(mem_addr),  32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_cpu_ack",   32'(cpu_ack),   32'd0);
        chk("rst_aux_ack",   32'(aux_ack),   32'd0);
        pend = 0;
        wcnt = 0;
      end else if (pend != 0) begin
        chk("ack_mem_en",  32'(mem_en),  32'd0);
        chk("ack_cpu_ack", 32'(cpu_ack), (pend == 1) ? 32'd1 : 32'd0);
        chk("ack_aux_ack", 32'(aux_ack), (pend == 2) ? 32'd1 : 32'd0);
        if (!pend_we && pend == 1) chk("cpu_rdata", 32'(cpu_rdata), 32'(ref_mem[pend_addr[11:0]]));
        if (!pend_we && pend == 2) chk("aux_rdata", 32'(aux_rdata), 32'(ref_mem[pend_addr[11:0]]));
        pend = 0;
      end else begin
        if (aux_lock) g = aux_req ? 2 : 0;
        else if (cpu_req && aux_req) g = (wcnt >= MAXW) ? 2 : 1;
        else if (cpu_req) g = 1;
        else if (aux_req) g = 2;
        else g = 0;
        chk("idle_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("idle_aux_ack", 32'(aux_ack), 32'd0);
        chk("grant_mem_en", 32'(mem_en), (g != 0) ? 32'd1 : 32'd0);
        if (g != 0) begin
          pend_we   = (g == 1) ? cpu_we : aux_we;
          pend_addr = (g == 1) ? cpu_addr : aux_addr;
          chk("grant_mem_we",   32'(mem_we),   32'(pend_we));
          chk("grant_mem_addr", 32'(mem_addr), 32'(pend_addr));
          if (pend_we) begin
            chk("grant_mem_wdata", 32'(mem_wdata), 32'((g == 1) ? cpu_wdata : aux_wdata));
            ref_mem[pend_addr[11:0]] = (g == 1) ? cpu_wdata : aux_wdata;
          end
          if (g == 1 && aux_req) wcnt = (wcnt < 15) ? wcnt + 1 : 15;
          if (g == 2) wcnt = 0;
        end
        pend = g;
      end
      cyc_cnt++;
    end
  end

  // Directed stimulus with cycle-pinned literal expectations.
  initial begin
    rst = 1'b1; aux_lock = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010; cpu_wdata = 16'h0000;
    aux_req = 1'b0; aux_we = 1'b0; aux_addr = 16'h0000; aux_wdata = 16'h0000;

    // Reset held with a CPU request pending.
    repeat (3) begin
      pin(0, S_MEM_EN, 16'd0);
      pin(0, S_CPU_ACK, 16'd0);
      cyc();
    end
    cyc();

    // First cycle out of reset grants the CPU read of 0x0010.
    rst = 1'b0;
    pin(0, S_MEM_EN, 16'd1);
    pin(0, S_MEM_ADDR, 16'h0010);
    pin(1, S_CPU_ACK, 16'd1);
    pin(1, S_CPU_RDATA, 16'h1234);
    cyc();
    cyc();
    cpu_req = 1'b0;

    // Continuous contention: CPU x4 then aux, repeating.
    cpu_req = 1'b1; cpu_addr = 16'h0020;
    aux_req = 1'b1; aux_addr = 16'h0030;
    for (int i = 0; i < 10; i++) begin
      pin(2 * i, S_MEM_EN, 16'd1);
      pin(2 * i, S_MEM_ADDR, (i % 5 == 4) ? 16'h0030 : 16'h0020);
      pin(2 * i + 1, S_MEM_EN, 16'd0);
      if (i % 5 == 4) pin(2 * i + 1, S_AUX_RDATA, 16'h6666);
      else pin(2 * i + 1, S_CPU_RDATA, 16'h5555);
    end
    repeat (20) cyc();

    // Aux lock: aux write goes through, CPU starved until the lock drops.
    aux_lock = 1'b1;
    cpu_addr = 16'h0100;
    aux_we = 1'b1; aux_addr = 16'h0100; aux_wdata = 16'hBEEF;
    pin(0, S_MEM_EN, 16'd1);
    pin(0, S_MEM_WE, 16'd1);
    pin(0, S_MEM_ADDR, 16'h0100);
    pin(0, S_MEM_WDATA, 16'hBEEF);
    pin(1, S_AUX_ACK, 16'd1);
    pin(1, S_CPU_ACK, 16'd0);
    cyc();
    cyc();
    aux_req = 1'b0; aux_we = 1'b0;
    repeat (3) begin
      pin(0, S_MEM_EN, 16'd0);
      pin(0, S_CPU_ACK, 16'd0);
      cyc();
    end
    aux_lock = 1'b0;
    pin(0, S_MEM_EN, 16'd1);
    pin(0, S_MEM_ADDR, 16'h0100);
    pin(1, S_CPU_ACK, 16'd1);
    pin(1, S_CPU_RDATA, 16'hBEEF);
    cyc();
    cyc();
    cpu_req = 1'b0;

    // Reset lands in the aux write's ack cycle.
    aux_req = 1'b1; aux_we = 1'b1; aux_addr = 16'h0200; aux_wdata = 16'h00AA;
    pin(0, S_MEM_EN, 16'd1);
    pin(0, S_MEM_WDATA, 16'h00AA);
    cyc();
    rst = 1'b1;
    pin(0, S_AUX_ACK, 16'd0);
    cyc();
    rst = 1'b0;
    aux_req = 1'b0; aux_we = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0200;
    pin(0, S_MEM_EN, 16'd1);
    pin(0, S_MEM_ADDR, 16'h0200);
    pin(1, S_CPU_ACK, 16'd1);
    pin(1, S_CPU_RDATA, 16'h00AA);
    cyc();
    cyc();
    cpu_req = 1'b0;

    // One-cycle aux pulse loses to the CPU and is abandoned.
    cpu_req = 1'b1; cpu_addr = 16'h0020;
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 16'h0030;
    pin(0, S_MEM_ADDR, 16'h0020);
    cyc();
    aux_req = 1'b0;
    pin(0, S_AUX_ACK, 16'd0);
    cyc();

    // Starvation count is now 1, so aux wins after three more CPU grants.
    aux_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pin(2 * i, S_MEM_EN, 16'd1);
      pin(2 * i, S_MEM_ADDR, (i == 3) ? 16'h0030 : 16'h0020);
    end
    repeat (8) cyc();
    cpu_req = 1'b0;
    aux_req = 1'b0;
    repeat (3) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
